// File: rtl/led_cnt_pkg.sv
// Shared types and helpers for the multi-channel LED divider/blinker.
// Build option: LED_CNT_IRQ_STICKY_EN makes the per-channel interrupt a sticky W1C bit.
package led_cnt_pkg;

  localparam int LED_PRESCALE_DEF = 100000;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    BLINK   = 2'd2,
    ONESHOT = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_BLINK = 2'd2,
    S_SHOT  = 2'd3
  } led_state_e;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_cnt_ch.sv
// One LED channel: config register, terminal-count divider, mode FSM and interrupt.
// Build option: LED_CNT_IRQ_STICKY_EN selects a sticky interrupt cleared by irq_clr_i.
module led_cnt_ch
  import led_cnt_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             clk100,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             wr_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             irq_clr_i,
  output logic             led_o,
  output logic             irq_o
);

  typedef struct packed {
    led_mode_e        mode;
    logic [DIV_W-1:0] div;
  } led_cfg_t;

  led_cfg_t         cfg_q, cfg_d;
  led_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             irq_q, irq_d;
  logic             tc;

  always_comb begin
    cfg_d   = cfg_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    tc      = 1'b0;
    // A write always wins over a terminal count landing on the same edge.
    if (wr_i) begin
      cfg_d.mode = led_mode_e'(mode_i);
      cfg_d.div  = div_i;
      cnt_d      = '0;
      case (led_mode_e'(mode_i))
        OFF:     begin state_d = S_OFF;   led_d = 1'b0; end
        ON:      begin state_d = S_ON;    led_d = 1'b1; end
        BLINK:   begin state_d = S_BLINK; led_d = 1'b0; end
        default: begin state_d = S_SHOT;  led_d = 1'b1; end
      endcase
    end else if (tick_i && (cfg_q.mode == BLINK || cfg_q.mode == ONESHOT) &&
                 (cfg_q.div != '0)) begin
      if (cnt_q == cfg_q.div - DIV_W'(1)) begin
        cnt_d = '0;
        tc    = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (tc) begin
      if (state_q == S_SHOT) begin
        led_d      = 1'b0;
        state_d    = S_OFF;
        cfg_d.mode = OFF;
      end else begin
        led_d = ~led_q;
      end
    end

`ifdef LED_CNT_IRQ_STICKY_EN
    irq_d = tc | (irq_q & ~irq_clr_i);
`else
    irq_d = tc;
`endif
  end

`ifndef LED_CNT_IRQ_STICKY_EN
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
`endif

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      state_q <= S_OFF;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      irq_q   <= irq_d;
    end
  end

  assign led_o = led_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/led_cnt_multi.sv
// Multi-channel LED divider/blinker: shared base-tick prescaler plus NUM_CH channels.
// Build option: LED_CNT_IRQ_STICKY_EN turns led_int_o into sticky bits cleared by irq_clr_i.
module led_cnt_multi
  import led_cnt_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 12,
  parameter int PRESCALE = LED_PRESCALE_DEF
) (
  input  logic                        clk100,
  input  logic                        rst_n,
  input  logic [DIV_W-1:0]            div_i,
  input  logic [1:0]                  mode_i,
  input  logic [ch_width(NUM_CH)-1:0] ch_sel_i,
  input  logic                        wren_i,
  input  logic [NUM_CH-1:0]           irq_clr_i,
  output logic [NUM_CH-1:0]           led_int_o,
  output logic [NUM_CH-1:0]           led_o
);

  localparam int              CH_W    = ch_width(NUM_CH);
  localparam int              PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  assign tick = (ps_q == PS_LAST);
  assign ps_d = tick ? '0 : ps_q + PS_W'(1);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  // Out-of-range selects match no channel, so such writes are silently dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = wren_i && (ch_sel_i == CH_W'(i));

    led_cnt_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk100    (clk100),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .wr_i      (wr),
      .mode_i    (mode_i),
      .div_i     (div_i),
      .irq_clr_i (irq_clr_i[i]),
      .led_o     (led_o[i]),
      .irq_o     (led_int_o[i])
    );
  end

endmodule
